// File: rtl/beamformer_pkg.sv
// Shared defaults, delay-index width and FSM state encoding for the beam-sum datapath.
package beamformer_pkg;

  localparam int DEF_NUMBER_OF_CHANNELS = 2;
  localparam int DEF_NUMBER_OF_BITS     = 8;
  localparam int DEF_BUFFER_SIZE        = 10;
  localparam int DELAY_WIDTH            = $clog2(DEF_BUFFER_SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SHIFT
  } state_t;

  function automatic int delay_width(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/delay_table.sv
// Per-channel delay registers: clamped writes, out-of-range selects dropped, write-through read port.
module delay_table
  import beamformer_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUMBER_OF_CHANNELS,
  parameter int BUF_SIZE = DEF_BUFFER_SIZE,
  parameter int DW       = delay_width(DEF_BUFFER_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  input  logic          cfg_ready,
  input  logic [2:0]    cfg_sel,
  input  logic [DW-1:0] cfg_delay,
  input  logic [2:0]    rd_sel,
  output logic [DW-1:0] rd_delay
);

  logic          wr_en;
  logic [DW-1:0] clamped;
  logic [NUM_CH*DW-1:0] delay_next_flat;

  assign wr_en   = cfg_valid && cfg_ready;
  assign clamped = (cfg_delay >= DW'(BUF_SIZE)) ? DW'(BUF_SIZE - 1) : cfg_delay;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dly
    logic [DW-1:0] delay_q;
    logic [DW-1:0] delay_d;

    always_comb begin
      delay_d = delay_q;
      if (wr_en && (cfg_sel == 3'(gi))) delay_d = clamped;
    end

    always_ff @(posedge clk) begin
      if (reset) delay_q <= '0;
      else       delay_q <= delay_d;
    end

    assign delay_next_flat[gi*DW +: DW] = delay_d;
  end

  // Reading the post-write value lets a write coinciding with frame_start steer that frame.
  always_comb begin
    rd_delay = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == 3'(i)) rd_delay = delay_next_flat[i*DW +: DW];
    end
  end

endmodule

// File: rtl/beam_sum_scheduler.sv
// Sequences one sample per channel buffer each frame, averages them and streams the result MSB first.
module beam_sum_scheduler
  import beamformer_pkg::*;
#(
  parameter int NUMBER_OF_CHANNELS = DEF_NUMBER_OF_CHANNELS,
  parameter int NUMBER_OF_BITS     = DEF_NUMBER_OF_BITS,
  parameter int BUFFER_SIZE        = DEF_BUFFER_SIZE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          cfg_valid,
  input  logic [2:0]                    cfg_sel,
  input  logic [$clog2(BUFFER_SIZE):0]  cfg_delay,
  output logic                          cfg_ready,
  output logic [2:0]                    rd_chan,
  output logic [$clog2(BUFFER_SIZE):0]  rd_index,
  input  logic [NUMBER_OF_BITS-1:0]     rd_data,
  output logic                          dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int DW    = delay_width(BUFFER_SIZE);
  localparam int NB    = NUMBER_OF_BITS;
  localparam int LOG_N = $clog2(NUMBER_OF_CHANNELS);
  localparam int AW    = NB + LOG_N;
  localparam int BCW   = $clog2(NB) + 1;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d, acc_sum;
  logic [2:0]            chan_q, chan_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic [NB-1:0]         shreg_q, shreg_d, word;
  logic                  dout_q, dout_d, dout_valid_q, dout_valid_d;
  logic                  busy_q, busy_d, overrun_q, overrun_d, cfg_ready_q, cfg_ready_d;
  logic [2:0]            rd_chan_q, rd_chan_d, lookup_sel;
  logic [DW-1:0]         rd_index_q, rd_index_d, lookup_delay;

  delay_table #(
    .NUM_CH   (NUMBER_OF_CHANNELS),
    .BUF_SIZE (BUFFER_SIZE),
    .DW       (DW)
  ) u_delay_table (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready_q),
    .cfg_sel   (cfg_sel),
    .cfg_delay (cfg_delay),
    .rd_sel    (lookup_sel),
    .rd_delay  (lookup_delay)
  );

  assign acc_sum = acc_q + AW'($signed(rd_data));
  assign word    = NB'(acc_sum >>> LOG_N);

  // rd_chan/rd_index are registered one step ahead so they are stable for the whole READ cycle.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    chan_d       = chan_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    rd_chan_d    = '0;
    rd_index_d   = '0;
    lookup_sel   = '0;
    overrun_d    = overrun_q;
    if (frame_start && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d    = READ;
          acc_d      = '0;
          chan_d     = '0;
          rd_index_d = lookup_delay;
        end
      end
      READ: begin
        acc_d = acc_sum;
        if (chan_q == 3'(NUMBER_OF_CHANNELS - 1)) begin
          state_d      = SHIFT;
          shreg_d      = word << 1;
          dout_d       = word[NB-1];
          dout_valid_d = 1'b1;
          bit_d        = '0;
        end else begin
          chan_d     = chan_q + 3'd1;
          lookup_sel = chan_q + 3'd1;
          rd_chan_d  = chan_q + 3'd1;
          rd_index_d = lookup_delay;
        end
      end
      SHIFT: begin
        if (bit_q == BCW'(NB - 1)) begin
          state_d = IDLE;
        end else begin
          dout_d       = shreg_q[NB-1];
          dout_valid_d = 1'b1;
          shreg_d      = shreg_q << 1;
          bit_d        = bit_q + BCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    cfg_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      chan_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      cfg_ready_q  <= 1'b0;
      rd_chan_q    <= '0;
      rd_index_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      chan_q       <= chan_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      cfg_ready_q  <= cfg_ready_d;
      rd_chan_q    <= rd_chan_d;
      rd_index_q   <= rd_index_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign cfg_ready  = cfg_ready_q;
  assign rd_chan    = rd_chan_q;
  assign rd_index   = rd_index_q;

endmodule

// File: tb/tb_beam_sum_scheduler.sv
// Scoreboard bench: frames push expected words/indices, a negedge monitor reassembles dout and compares.
module tb_beam_sum_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       cfg_valid;
  logic [2:0] cfg_sel;
  logic [4:0] cfg_delay;
  logic       cfg_ready;
  logic [2:0] rd_chan;
  logic [4:0] rd_index;
  logic [7:0] rd_data;
  logic       dout, dout_valid, busy, overrun;

  logic [7:0] mem [8][32];

  typedef struct {
    logic [7:0] w;
    logic [4:0] i0;
    logic [4:0] i1;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_frm  = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_chan][rd_index];

  beam_sum_scheduler #(
    .NUMBER_OF_CHANNELS (2),
    .NUMBER_OF_BITS     (8),
    .BUFFER_SIZE        (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .cfg_valid   (cfg_valid),
    .cfg_sel     (cfg_sel),
    .cfg_delay   (cfg_delay),
    .cfg_ready   (cfg_ready),
    .rd_chan     (rd_chan),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: cycle 1 of a frame is the first cycle busy is seen high.
  int         cyc = 0, nbits = 0, first = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] word = '0;
  logic [4:0] got_i0, got_i1;
  logic [2:0] got_c0, got_c1;

  always @(negedge clk) begin
    if (reset) begin
      cyc = 0; nbits = 0; busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) cyc = 1;
      else if (cyc != 0 && cyc < 1000) cyc++;
      busy_prev = busy;
      if (cyc == 1) begin got_i0 = rd_index; got_c0 = rd_chan; end
      if (cyc == 2) begin got_i1 = rd_index; got_c1 = rd_chan; end
      if (dout_valid) begin
        if (nbits == 0) first = cyc;
        word = {word[6:0], dout};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (sb.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL unexpected_word: got %02h expected none", word);
          end else begin
            exp_t e;
            e = sb.pop_front();
            n_frm++;
            $display("frame %0d: word=%02h expected=%02h idx=%0d,%0d first_cyc=%0d last_cyc=%0d",
                     n_frm, word, e.w, got_i0, got_i1, first, cyc);
            chk("word", word, e.w);
            chk("rd_index0", got_i0, e.i0);
            chk("rd_index1", got_i1, e.i1);
            chk("rd_chan0", got_c0, 0);
            chk("rd_chan1", got_c1, 1);
            chk("first_bit_cycle", first, 3);
            chk("last_bit_cycle", cyc, 10);
          end
        end
      end
    end
  end

  task automatic cfg_write(input logic [2:0] sel, input logic [4:0] dly);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_delay = dly;
    chk("cfg_ready_idle", cfg_ready, 1);
    tick;
    cfg_valid = 1'b0;
  endtask

  // extra_pulse: frame cycle at which a second frame_start is driven (0 = none).
  task automatic run_frame(input logic [7:0] s0, input logic [7:0] s1,
                           input logic [4:0] i0, input logic [4:0] i1, input logic [7:0] w,
                           input bit with_cfg, input logic [2:0] csel, input logic [4:0] cdly,
                           input int extra_pulse, input bit busy_cfg);
    exp_t e;
    for (int c = 0; c < 8; c++) for (int k = 0; k < 32; k++) mem[c][k] = 8'h00;
    mem[0][i0] = s0;
    mem[1][i1] = s1;
    e.w = w; e.i0 = i0; e.i1 = i1;
    sb.push_back(e);
    frame_start = 1'b1;
    if (with_cfg) begin
      cfg_valid = 1'b1; cfg_sel = csel; cfg_delay = cdly;
      chk("cfg_ready_with_frame", cfg_ready, 1);
    end
    tick;
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      frame_start = (c == extra_pulse);
      if (busy_cfg && c <= 10) begin
        cfg_valid = 1'b1; cfg_sel = 3'd7; cfg_delay = 5'd0;
        chk("cfg_ready_busy", cfg_ready, 0);
      end else begin
        cfg_valid = 1'b0;
      end
      if (extra_pulse == 10 && c == 11) chk("busy_after_late_pulse", busy, 0);
      tick;
    end
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    if (extra_pulse != 0) chk("overrun_set", overrun, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; cfg_delay = '0;
    for (int c = 0; c < 8; c++) for (int k = 0; k < 32; k++) mem[c][k] = 8'h00;
    repeat (3) tick;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_rd_chan", rd_chan, 0);
    chk("rst_rd_index", rd_index, 0);
    reset = 1'b0;
    tick;

    cfg_write(3'd0, 5'd0);
    cfg_write(3'd1, 5'd3);
    run_frame(8'h10, 8'h20, 5'd0, 5'd3, 8'h18, 0, 3'd0, 5'd0, 0, 0);
    run_frame(8'h80, 8'h80, 5'd0, 5'd3, 8'h80, 0, 3'd0, 5'd0, 0, 0);
    run_frame(8'h7F, 8'h7F, 5'd0, 5'd3, 8'h7F, 0, 3'd0, 5'd0, 0, 0);
    run_frame(8'hFF, 8'h00, 5'd0, 5'd3, 8'hFF, 0, 3'd0, 5'd0, 0, 0);
    run_frame(8'h70, 8'h90, 5'd0, 5'd3, 8'h00, 0, 3'd0, 5'd0, 0, 0);

    cfg_write(3'd1, 5'd15);
    run_frame(8'h40, 8'h20, 5'd0, 5'd9, 8'h30, 0, 3'd0, 5'd0, 0, 0);
    cfg_write(3'd5, 5'd2);
    run_frame(8'h02, 8'h04, 5'd0, 5'd9, 8'h03, 0, 3'd0, 5'd0, 0, 0);

    // Delay write in the same cycle as frame_start steers that frame.
    run_frame(8'h06, 8'h0A, 5'd5, 5'd9, 8'h08, 1, 3'd0, 5'd5, 0, 0);
    // frame_start on the final SHIFT cycle is ignored.
    run_frame(8'h11, 8'h33, 5'd5, 5'd9, 8'h22, 0, 3'd0, 5'd0, 10, 0);

    // Reset in cycle 6 of a frame aborts it; nothing is expected from it.
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    repeat (5) tick;
    reset = 1'b1;
    tick;
    chk("abort_dout_valid", dout_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_rd_index", rd_index, 0);
    chk("abort_cfg_ready", cfg_ready, 0);
    reset = 1'b0;
    tick;

    run_frame(8'h20, 8'h60, 5'd0, 5'd0, 8'h40, 0, 3'd0, 5'd0, 0, 0);
    run_frame(8'h08, 8'h18, 5'd0, 5'd0, 8'h10, 0, 3'd0, 5'd0, 4, 1);
    run_frame(8'hC0, 8'hC0, 5'd0, 5'd0, 8'hC0, 0, 3'd0, 5'd0, 0, 0);
    chk("overrun_sticky", overrun, 1);

    repeat (3) tick;
    chk("scoreboard_empty", sb.size(), 0);
    chk("partial_bits", nbits, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/beam_sum_scheduler.md
BEAM_SUM_SCHEDULER -- requirements
Module: beam_sum_scheduler

Interface
REQ-001 SHALL have parameter NUMBER_OF_CHANNELS, default 2, meaning number of channel buffers sequenced (power of two, 1..8).
REQ-002 SHALL have parameter NUMBER_OF_BITS, default 8, meaning signed two's-complement sample width.
REQ-003 SHALL have parameter BUFFER_SIZE, default 10, meaning depth of each channel buffer.
REQ-004 SHALL use one clock and a synchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-005 SHALL have port clk  input  1  the single system clock, with all state on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse once per audio frame (ws edge).
REQ-008 SHALL have port cfg_valid  input  1  delay write request.
REQ-009 SHALL have port cfg_sel  input  3  channel whose delay is written.
REQ-010 SHALL have port cfg_delay  input  $clog2(BUFFER_SIZE)+1  delay in samples.
REQ-011 SHALL have port cfg_ready  output  1  delay write accepted this cycle when high together with cfg_valid.
REQ-012 SHALL have port rd_chan  output  3  channel buffer currently selected.
REQ-013 SHALL have port rd_index  output  $clog2(BUFFER_SIZE)+1  read index into the selected buffer.
REQ-014 SHALL have port rd_data  input  NUMBER_OF_BITS  combinational sample from the selected buffer.
REQ-015 SHALL have port dout  output  1  serial beam sample, MSB first.
REQ-016 SHALL have port dout_valid  output  1  high while dout carries a bit.
REQ-017 SHALL have port busy  output  1  high from the accepted frame_start until the last bit is sent.
REQ-018 SHALL have port overrun  output  1  sticky flag for a frame_start that arrived while busy.

Function
REQ-019 SHALL implement an FSM with states IDLE, READ and SHIFT.
REQ-020 IDLE SHALL move to READ on frame_start, clear the accumulator and set the channel counter to 0.
REQ-021 READ, with counter c, SHALL drive rd_chan=c and rd_index=delay[c], and add sign-extended rd_data to the accumulator that same cycle.
REQ-022 READ SHALL last exactly NUMBER_OF_CHANNELS cycles and then go to SHIFT.
REQ-023 Accumulator width SHALL be NUMBER_OF_BITS+$clog2(NUMBER_OF_CHANNELS), so it cannot overflow.
REQ-024 On entering SHIFT, the output word SHALL be the accumulator arithmetically shifted right by $clog2(NUMBER_OF_CHANNELS), truncated to NUMBER_OF_BITS.
REQ-025 SHIFT SHALL drive dout MSB first with dout_valid=1 for exactly NUMBER_OF_BITS cycles, then return to IDLE.
REQ-026 Latency: with frame_start at cycle 0, the first bit SHALL appear at cycle NUMBER_OF_CHANNELS+1 and the last at cycle NUMBER_OF_CHANNELS+NUMBER_OF_BITS.
REQ-027 frame_start while busy SHALL be ignored and SHALL set overrun.
REQ-028 frame_start in the same cycle as the SHIFT-to-IDLE transition SHALL count as busy and SHALL set overrun.
REQ-029 cfg_ready SHALL be high only in IDLE, so delays never change mid-frame.
REQ-030 A write to a delay register SHALL take effect from the next frame.
REQ-031 cfg_ready and frame_start in the same IDLE cycle SHALL write the delay first; the new value SHALL be used by that frame.
REQ-032 cfg_delay >= BUFFER_SIZE SHALL be clamped to BUFFER_SIZE-1.
REQ-033 cfg_sel >= NUMBER_OF_CHANNELS SHALL be accepted (handshake completes) and discarded.
REQ-034 Outside READ, rd_chan and rd_index SHALL hold 0.
REQ-035 Outside SHIFT, dout and dout_valid SHALL be 0.

Reset
REQ-036 Reset SHALL force: state=IDLE, all delay registers=0, accumulator=0, counters=0.
REQ-037 During reset the outputs SHALL be: dout=0, dout_valid=0, busy=0, overrun=0, rd_chan=0, rd_index=0, cfg_ready=0.
REQ-038 Reset asserted mid-READ or mid-SHIFT SHALL abort the frame with no further dout bits, and outputs SHALL equal their reset values on the next cycle.

Structure
REQ-039 A shared package beamformer_pkg SHALL hold the default NUMBER_OF_CHANNELS, NUMBER_OF_BITS and BUFFER_SIZE, the DELAY_WIDTH constant and the FSM state typedef.
REQ-040 The delay register file with clamping and write handshake SHALL be a sub-module delay_table; the rest (FSM, accumulator, shifter) stays in beam_sum_scheduler.

Verification (N=2, bits=8, size=10)
REQ-041 Write delays ch0=0 and ch1=3; frame_start with rd_data 0x10 at idx0/ch0 and 0x20 at idx3/ch1 -> rd_index sequence 0,3, dout 00011000 (0x18) at cycles 3..10.
REQ-042 Both samples 0x80 -> dout 10000000 (-128 preserved); both samples 0x7F -> 01111111.
REQ-043 cfg_delay=15 on ch1 -> next frame reads rd_index=9; cfg_sel=5 -> cfg_ready handshake completes and ch0/ch1 delays are unchanged.
REQ-044 frame_start at cycle 4 of a frame -> output stream unchanged, overrun=1 and stays 1 until reset; cfg_valid during busy -> cfg_ready=0 until IDLE.
REQ-045 Reset asserted at cycle 6 of a frame -> dout_valid=0 and busy=0 from cycle 7, delays read 0 afterwards, and the next frame_start runs normally.
